aidc_lite_comp_zrle: RTL and testbench

- Zero-run-length compressor: the encode-side counterpart of the decompressor's ZRLE path.
- Reads one uncompressed block from the shared AIDC_LITE_BUFFER: 2^ADDR_WIDTH words of 64 bits, read latency 1.
- Emits a 32-bit ZRLE token stream with sop/eop framing over a valid/ready interface, toward the engine's AHB write path.
- Reports the emitted word count when finished.

---
 rtl/aidc_lite_comp_zrle.sv | 176 +++++++++++++++++
 tb/tb_aidc_lite_comp_zrle.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/aidc_lite_comp_zrle.sv
// ============================================================================
//  Module   : aidc_lite_comp_zrle
//  Purpose  : Zero-run-length encoder reading one 64-bit buffer block and
//             emitting a framed 32-bit header/literal/terminator token stream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aidc_lite_comp_zrle #(
    parameter int ADDR_WIDTH = 4,
    parameter int RUN_W      = ADDR_WIDTH + 2,
    parameter int CNT_W      = ADDR_WIDTH + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      word_cnt_o,
    output logic [ADDR_WIDTH-1:0] buf_raddr_o,
    input  logic [63:0]           buf_rdata_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic [31:0]           data_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_WAIT, S_SCAN_LO, S_SCAN_HI, S_HDR, S_LIT, S_TERM, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] raddr_q,    raddr_d;
    logic [63:0]           word_q,     word_d;
    logic [RUN_W-1:0]      run_q,      run_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic                  sop_seen_q, sop_seen_d;
    logic                  lit_hi_q,   lit_hi_d;

    logic                  accept;
    logic [31:0]           elem_lo;
    logic [31:0]           elem_hi;

    assign elem_lo = word_q[31:0];
    assign elem_hi = word_q[63:32];

    // Outputs decode only from registered state, so ready_i never reaches valid_o.
    always_comb begin
        valid_o     = (state_q == S_HDR) || (state_q == S_LIT) || (state_q == S_TERM);
        sop_o       = valid_o && !sop_seen_q;
        eop_o       = (state_q == S_TERM);
        done_o      = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
        word_cnt_o  = word_cnt_q;
        buf_raddr_o = raddr_q;
        accept      = valid_o && ready_i;
        case (state_q)
            S_HDR:   data_o = {{(32-RUN_W){1'b0}}, run_q};
            S_LIT:   data_o = lit_hi_q ? elem_hi : elem_lo;
            S_TERM:  data_o = {1'b1, {(31-RUN_W){1'b0}}, run_q};
            default: data_o = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        raddr_d    = raddr_q;
        word_d     = word_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        word_cnt_d = word_cnt_q;
        sop_seen_d = sop_seen_q;
        lit_hi_d   = lit_hi_q;

        if (accept) begin
            cnt_d      = cnt_q + CNT_W'(1);
            sop_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    run_d      = '0;
                    cnt_d      = '0;
                    sop_seen_d = 1'b0;
                    raddr_d    = '0;
                    state_d    = S_RD;
                end
            end
            S_RD:   state_d = S_WAIT;
            S_WAIT: begin
                word_d  = buf_rdata_i;
                state_d = S_SCAN_LO;
            end
            S_SCAN_LO: begin
                if (elem_lo != 32'h0) begin
                    lit_hi_d = 1'b0;
                    state_d  = S_HDR;
                end else begin
                    run_d   = run_q + RUN_W'(1);
                    state_d = S_SCAN_HI;
                end
            end
            S_SCAN_HI: begin
                if (elem_hi != 32'h0) begin
                    lit_hi_d = 1'b1;
                    state_d  = S_HDR;
                end else begin
                    run_d = run_q + RUN_W'(1);
                    if (raddr_q == LAST_ADDR) begin
                        state_d = S_TERM;
                    end else begin
                        raddr_d = raddr_q + ADDR_WIDTH'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_HDR: begin
                if (accept) begin
                    run_d   = '0;
                    state_d = S_LIT;
                end
            end
            S_LIT: begin
                // A literal from the low half still has the high half to scan.
                if (accept) begin
                    if (!lit_hi_q) begin
                        state_d = S_SCAN_HI;
                    end else if (raddr_q == LAST_ADDR) begin
                        state_d = S_TERM;
                    end else begin
                        raddr_d = raddr_q + ADDR_WIDTH'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_TERM: begin
                if (accept) begin
                    word_cnt_d = cnt_q + CNT_W'(1);
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            raddr_q    <= '0;
            word_q     <= '0;
            run_q      <= '0;
            cnt_q      <= '0;
            word_cnt_q <= '0;
            sop_seen_q <= 1'b0;
            lit_hi_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            word_q     <= word_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            word_cnt_q <= word_cnt_d;
            sop_seen_q <= sop_seen_d;
            lit_hi_q   <= lit_hi_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aidc_lite_comp_zrle.sv
// ============================================================================
//  Module   : tb_aidc_lite_comp_zrle
//  Purpose  : Directed self-checking bench for the ZRLE compressor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aidc_lite_comp_zrle;

    localparam int ADDR_WIDTH = 4;
    localparam int CNT_W      = ADDR_WIDTH + 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_i = 1'b0;
    logic                  busy_o;
    logic                  done_o;
    logic [CNT_W-1:0]      word_cnt_o;
    logic [ADDR_WIDTH-1:0] buf_raddr_o;
    logic [63:0]           buf_rdata_i = '0;
    logic                  valid_o;
    logic                  ready_i = 1'b0;
    logic                  sop_o;
    logic                  eop_o;
    logic [31:0]           data_o;

    logic [63:0] mem [16];
    logic [31:0] got_d [$];
    logic        got_sop [$];
    logic        got_eop [$];
    logic [31:0] exp_d [$];
    int          done_cnt, stall_err, stall_cnt;
    bit          timed_out;
    int          n_cmp = 0;
    int          n_fail = 0;

    aidc_lite_comp_zrle #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o),
        .done_o(done_o), .word_cnt_o(word_cnt_o), .buf_raddr_o(buf_raddr_o),
        .buf_rdata_i(buf_rdata_i), .valid_o(valid_o), .ready_i(ready_i),
        .sop_o(sop_o), .eop_o(eop_o), .data_o(data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) buf_rdata_i <= mem[buf_raddr_o];

    task automatic load_single();
        for (int k = 0; k < 16; k++) mem[k] = 64'h0;
        mem[3] = 64'hDEAD_0000_0000_0000;
        exp_d = '{32'h0000_0007, 32'hDEAD_0000, 32'h8000_0018};
    endtask

    // bp = percent chance of ready_i low per cycle; dup = pulse start again mid-block
    task automatic run_block(input int bp, input bit dup);
        bit          stalled;
        int          post;
        logic [31:0] pd;
        logic        ps, pe;
        logic [3:0]  pa;
        got_d.delete(); got_sop.delete(); got_eop.delete();
        done_cnt = 0; stall_err = 0; stall_cnt = 0; stalled = 0; post = 0;
        @(negedge clk); start_i = 1'b1; ready_i = 1'b0;
        @(negedge clk); start_i = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start_i = (dup && (cyc == 5 || cyc == 9));
            ready_i = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
            if (stalled) begin
                if (valid_o !== 1'b1 || data_o !== pd || sop_o !== ps ||
                    eop_o !== pe || buf_raddr_o !== pa) stall_err++;
            end
            if (valid_o && ready_i) begin
                got_d.push_back(data_o); got_sop.push_back(sop_o); got_eop.push_back(eop_o);
            end
            stalled = valid_o && !ready_i;
            if (stalled) stall_cnt++;
            pd = data_o; ps = sop_o; pe = eop_o; pa = buf_raddr_o;
            if (done_o) done_cnt++;
            if (done_cnt > 0) post++;
            if (post > 4) break;
            @(negedge clk);
        end
        start_i = 1'b0;
        ready_i = 1'b0;
        timed_out = (done_cnt == 0);
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (valid_o !== 1'b0 || sop_o !== 1'b0 || eop_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_handshake: valid=%b sop=%b eop=%b, required 0 0 0", valid_o, sop_o, eop_o); end
        n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: busy=%b done=%b, required 0 0", busy_o, done_o); end
        n_cmp++; if (data_o !== 32'h0 || buf_raddr_o !== 4'h0 || word_cnt_o !== 7'h0) begin
            n_fail++; $display("FAIL reset_data: data=%h raddr=%h cnt=%0d, required 0", data_o, buf_raddr_o, word_cnt_o); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        for (int k = 0; k < 16; k++) mem[k] = 64'h0;
        run_block(0, 1'b0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL zero_timeout: no done_o, required one"); end
        n_cmp++; if (got_d.size() != 1) begin
            n_fail++; $display("FAIL zero_len: got %0d words, required 1", got_d.size()); end
        else begin
            n_cmp++; if (got_d[0] !== 32'h8000_0020 || got_sop[0] !== 1'b1 || got_eop[0] !== 1'b1) begin
                n_fail++; $display("FAIL zero_term: data=%h sop=%b eop=%b, required 80000020 1 1", got_d[0], got_sop[0], got_eop[0]); end
        end
        n_cmp++; if (word_cnt_o !== 7'd1 || done_cnt != 1) begin
            n_fail++; $display("FAIL zero_cnt: word_cnt=%0d done=%0d, required 1 1", word_cnt_o, done_cnt); end
    endtask

    task automatic test_all_nonzero();
        for (int k = 0; k < 16; k++) mem[k] = {32'(2*k+2), 32'(2*k+1)};
        run_block(0, 1'b0);
        n_cmp++; if (timed_out || got_d.size() != 65) begin
            n_fail++; $display("FAIL full_len: got %0d words timeout=%b, required 65", got_d.size(), timed_out); end
        else begin
            for (int i = 0; i < 65; i++) begin
                logic [31:0] e;
                e = (i == 64) ? 32'h8000_0000 : ((i % 2 == 0) ? 32'h0 : 32'(i/2 + 1));
                n_cmp++; if (got_d[i] !== e || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 64)) begin
                    n_fail++; $display("FAIL full_word%0d: data=%h sop=%b eop=%b, required %h %b %b",
                                       i, got_d[i], got_sop[i], got_eop[i], e, i == 0, i == 64); end
            end
        end
        n_cmp++; if (word_cnt_o !== 7'd65) begin
            n_fail++; $display("FAIL full_cnt: word_cnt=%0d, required 65", word_cnt_o); end
    endtask

    task automatic test_single_literal();
        load_single();
        run_block(0, 1'b0);
        n_cmp++; if (timed_out || got_d.size() != 3) begin
            n_fail++; $display("FAIL single_len: got %0d words, required 3", got_d.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i] || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 2)) begin
                n_fail++; $display("FAIL single_word%0d: data=%h sop=%b eop=%b, required %h", i, got_d[i], got_sop[i], got_eop[i], exp_d[i]); end
        end
        n_cmp++; if (word_cnt_o !== 7'd3) begin
            n_fail++; $display("FAIL single_cnt: word_cnt=%0d, required 3", word_cnt_o); end
    endtask

    task automatic test_backpressure();
        load_single();
        run_block(50, 1'b0);
        n_cmp++; if (timed_out || got_d.size() != 3) begin
            n_fail++; $display("FAIL bp_len: got %0d words, required 3", got_d.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i] || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 2)) begin
                n_fail++; $display("FAIL bp_word%0d: data=%h, required %h", i, got_d[i], exp_d[i]); end
        end
        n_cmp++; if (stall_err != 0 || stall_cnt == 0) begin
            n_fail++; $display("FAIL bp_stable: unstable stalls=%0d of %0d, required 0 of >0", stall_err, stall_cnt); end
        n_cmp++; if (word_cnt_o !== 7'd3) begin
            n_fail++; $display("FAIL bp_cnt: word_cnt=%0d, required 3", word_cnt_o); end
    endtask

    task automatic test_busy_start();
        load_single();
        run_block(0, 1'b1);
        n_cmp++; if (timed_out || got_d.size() != 3) begin
            n_fail++; $display("FAIL busy_len: got %0d words, required 3", got_d.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL busy_word%0d: data=%h, required %h", i, got_d[i], exp_d[i]); end
        end
        n_cmp++; if (done_cnt != 1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL busy_done: done pulses=%0d busy=%b, required 1 0", done_cnt, busy_o); end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        load_single();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 0; c < 200; c++) begin
            ready_i = 1'b1;
            if (valid_o && data_o == 32'h7 && !eop_o) begin hit = 1; @(negedge clk); break; end
            @(negedge clk);
        end
        ready_i = 1'b0;
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL rstmid_hdr: header 00000007 not seen"); end
        repeat (2) @(negedge clk);
        n_cmp++; if (valid_o !== 1'b1 || data_o !== 32'hDEAD_0000) begin
            n_fail++; $display("FAIL rstmid_lit: valid=%b data=%h, required 1 dead0000", valid_o, data_o); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (valid_o !== 1'b0 || data_o !== 32'h0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
                     buf_raddr_o !== 4'h0 || word_cnt_o !== 7'h0 || sop_o !== 1'b0 || eop_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: valid=%b data=%h busy=%b done=%b raddr=%h cnt=%0d, required all 0",
                               valid_o, data_o, busy_o, done_o, buf_raddr_o, word_cnt_o); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: done=%b valid=%b, required 0 0", done_o, valid_o); end
        run_block(0, 1'b0);
        n_cmp++; if (timed_out || got_d.size() != 3) begin
            n_fail++; $display("FAIL rstmid_len: got %0d words, required 3", got_d.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i] || got_sop[i] !== (i == 0)) begin
                n_fail++; $display("FAIL rstmid_word%0d: data=%h sop=%b, required %h", i, got_d[i], got_sop[i], exp_d[i]); end
        end
        n_cmp++; if (word_cnt_o !== 7'd3 || done_cnt != 1) begin
            n_fail++; $display("FAIL rstmid_cnt: word_cnt=%0d done=%0d, required 3 1", word_cnt_o, done_cnt); end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 64'h0;
        test_reset();
        test_all_zero();
        test_all_nonzero();
        test_single_literal();
        test_backpressure();
        test_busy_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
